starfield_stack: RTL and testbench
==================================

STARFIELD_STACK -- requirements
Module: starfield_stack

Interface
REQ-001 Parameter WIDTH, default 400, active pixels per line.
REQ-002 Parameter HEIGHT, default 512, lines per frame; frame length L = WIDTH*HEIGHT.
REQ-003 Parameter LAYERS, default 3, number of star layers, legal range 1..8.
REQ-004 Parameter SPEED_STEP, default 1, drift of layer i = (i+1)*SPEED_STEP pixels per frame, legal while LAYERS*SPEED_STEP < L.
REQ-005 Parameter MASK, default 21'hFFF, density mask ORed with the LFSR before the star test.
REQ-006 Parameter BASE_SEED, default 21'h9A9A9, seed of layer i = BASE_SEED ^ (i*21'h0A5A5), replaced by 21'h00001 if zero.
REQ-007 pixel_clock  in  1  sole clock.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 frame_start  in  1  synchronous frame resync pulse.
REQ-010 pause  in  1  freezes all layer state while high.
REQ-011 layer_en  in  LAYERS  per-layer display enable; bit i gates layer i.
REQ-012 pixel_rgb  out  24  grey pixel {b,b,b}, registered.
REQ-013 star_on  out  1  a star is displayed this pixel, registered.
REQ-014 pixel_layer  out  3  index of the displayed layer, 0 when star_on=0, registered.

Function
REQ-015 Per layer: 21-bit Galois LFSR, right-shift, tap mask 21'h140000; one modulo-L pixel counter cnt, 0..L-1.
REQ-016 Each cycle with pause=0: cnt = (cnt==L-1) ? 0 : cnt+1.
REQ-017 Each cycle with pause=0: LFSR reloads its seed when cnt == L-1-(i+1)*SPEED_STEP, else steps once; the stars drift one speed step per frame.
REQ-018 Layer i star test: (lfsr | MASK) == 21'h1FFFFF; brightness = lfsr[7:0].
REQ-019 Priority: the highest-index enabled layer with its star test true wins, so nearer layers occlude farther ones.
REQ-020 Output latency 1 cycle: outputs at edge n+1 reflect layer state present in cycle n.
REQ-021 No winner: pixel_rgb=24'h0, star_on=0, pixel_layer=0.
REQ-022 frame_start=1: on the next edge every cnt=0 and every LFSR=seed; frame_start overrides pause.
REQ-023 pause=1 without frame_start: cnt and LFSR hold, and outputs keep recomputing from the held state.
REQ-024 layer_en changes only the selection, never layer state; a disabled layer keeps scrolling.

Reset
REQ-025 On reset_n=0, without waiting for a clock edge: cnt=0, LFSR=seed, pixel_rgb=0, star_on=0, pixel_layer=0, twinkle counters=0.
REQ-026 Reset release mid-frame is legal; the first post-reset frame starts at cnt=0.

Configuration
REQ-027 Macro STARFIELD_TWINKLE_EN defined: each layer gets an 8-bit frame counter, incremented when cnt wraps to 0 (not while paused), reset by frame_start; brightness = lfsr[7:0] ^ {frame_ctr[2:0],5'b0}.
REQ-028 Macro STARFIELD_TWINKLE_EN undefined: no frame counter; brightness exactly lfsr[7:0].

Structure
REQ-029 Package starfield_pkg holds LFSR width (21), tap mask, seed XOR step 21'h0A5A5, the zero-seed substitute, and a seed(i) function.
REQ-030 Sub-module starfield_layer (cnt, LFSR, twinkle counter, star test) is instantiated LAYERS times by a generate loop; the top level holds priority select and output register only.

Verification (WIDTH=8, HEIGHT=4, LAYERS=2, SPEED_STEP=1, MASK=21'h1FFFF0 unless stated)
REQ-031 reset_n=0 mid-run -> all outputs 0 immediately, before the next clock edge; first edge after release: layer LFSRs = 21'h9A9A9 and 21'h9A9A9^21'h0A5A5.
REQ-032 Free run 4 frames -> per-pixel star_on/pixel_rgb match the reference model bit-exact; layer 1 star columns drift 2 pixels per frame, layer 0 drift 1.
REQ-033 Force both star tests true (MASK=21'h1FFFFF), layer_en=2'b11 -> pixel_layer=1; layer_en=2'b01 -> pixel_layer=0; layer_en=2'b00 -> star_on=0, rgb=0.
REQ-034 pause=1 for 10 cycles -> outputs constant; pause=0 -> the sequence resumes from the held state, with no skipped pixel versus the model.
REQ-035 frame_start at cnt=17 while pause=1 -> the next edge gives cnt=0 and LFSR=seed; the output stream equals a post-reset stream.
REQ-036 STARFIELD_TWINKLE_EN defined -> frame 1 brightness = lfsr[7:0]^8'h20 at star pixels; undefined -> unchanged lfsr[7:0].

Source files
------------

// File: rtl/starfield_pkg.sv
// starfield_pkg: shared constants and the per-layer seed function for the
// starfield generator (LFSR width, Galois tap mask, seed spacing, and the
// non-zero substitute used when a layer seed would otherwise be all zeros).
package starfield_pkg;

  localparam int          LFSR_W    = 21;
  localparam logic [20:0] LFSR_TAPS = 21'h140000;
  localparam logic [20:0] SEED_STEP = 21'h0A5A5;
  localparam logic [20:0] ZERO_SUB  = 21'h00001;
  localparam logic [20:0] ALL_ONES  = 21'h1FFFFF;

  // An all-zero state would lock the LFSR, so it is swapped for ZERO_SUB.
  function automatic logic [20:0] seed(input logic [20:0] base, input int unsigned idx);
    logic [20:0] s;
    s = base ^ 21'(idx * SEED_STEP);
    if (s == '0) s = ZERO_SUB;
    return s;
  endfunction

endpackage

// File: rtl/starfield_layer.sv
// starfield_layer: one star layer -- modulo-L pixel counter, 21-bit Galois
// LFSR that reloads its seed slightly early each frame (so the star pattern
// drifts by (IDX+1)*SPEED_STEP pixels per frame), optional twinkle frame
// counter, and the star test.
//   pixel_clock, reset_n (async, active low), frame_start, pause : control
//   star_hit : star test true for the current layer state
//   bright   : star brightness for the current layer state
// Optional feature macro: STARFIELD_TWINKLE_EN (adds the 8-bit frame counter).
module starfield_layer
  import starfield_pkg::*;
#(
  parameter int          WIDTH      = 400,
  parameter int          HEIGHT     = 512,
  parameter int          IDX        = 0,
  parameter int          SPEED_STEP = 1,
  parameter logic [20:0] MASK       = 21'hFFF,
  parameter logic [20:0] BASE_SEED  = 21'h9A9A9
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       pause,
  output logic       star_hit,
  output logic [7:0] bright
);

  localparam int          L      = WIDTH * HEIGHT;
  localparam int          CW     = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST   = CW'(L - 1);
  localparam logic [CW-1:0] RELOAD = CW'(L - 1 - (IDX + 1) * SPEED_STEP);
  localparam logic [20:0] SEED   = seed(BASE_SEED, IDX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   lfsr_q, lfsr_d;

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (frame_start) begin
      cnt_d  = '0;
      lfsr_d = SEED;
    end else if (!pause) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      // Reloading (IDX+1)*SPEED_STEP pixels before the wrap shifts the
      // whole sequence left by that amount each frame.
      if (cnt_q == RELOAD) lfsr_d = SEED;
      else                 lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      lfsr_q <= SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign star_hit = ((lfsr_q | MASK) == ALL_ONES);

`ifdef STARFIELD_TWINKLE_EN
  logic [7:0] frame_ctr_q, frame_ctr_d;

  always_comb begin
    frame_ctr_d = frame_ctr_q;
    if (frame_start)                  frame_ctr_d = '0;
    else if (!pause && cnt_q == LAST) frame_ctr_d = frame_ctr_q + 8'd1;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) frame_ctr_q <= '0;
    else          frame_ctr_q <= frame_ctr_d;
  end

  assign bright = lfsr_q[7:0] ^ {frame_ctr_q[2:0], 5'b0};
`else
  assign bright = lfsr_q[7:0];
`endif

endmodule

// File: rtl/starfield_stack.sv
// starfield_stack: layered scrolling starfield. LAYERS starfield_layer
// instances scroll independently; the highest-index enabled layer with a
// star wins and drives a registered grey pixel.
//   pixel_clock, reset_n (async, active low)
//   frame_start : resync all layers to cnt=0 / seed (overrides pause)
//   pause       : freeze layer state
//   layer_en    : per-layer display enable (selection only)
//   pixel_rgb, star_on, pixel_layer : registered outputs, 1-cycle latency
// Optional feature macro: STARFIELD_TWINKLE_EN (see starfield_layer).
module starfield_stack
  import starfield_pkg::*;
#(
  parameter int          WIDTH      = 400,
  parameter int          HEIGHT     = 512,
  parameter int          LAYERS     = 3,
  parameter int          SPEED_STEP = 1,
  parameter logic [20:0] MASK       = 21'hFFF,
  parameter logic [20:0] BASE_SEED  = 21'h9A9A9
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              pause,
  input  logic [LAYERS-1:0] layer_en,
  output logic [23:0]       pixel_rgb,
  output logic              star_on,
  output logic [2:0]        pixel_layer
);

  logic [LAYERS-1:0]      hit;
  logic [LAYERS-1:0][7:0] bright;

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    starfield_layer #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .IDX       (g),
      .SPEED_STEP(SPEED_STEP),
      .MASK      (MASK),
      .BASE_SEED (BASE_SEED)
    ) u_layer (
      .pixel_clock(pixel_clock),
      .reset_n    (reset_n),
      .frame_start(frame_start),
      .pause      (pause),
      .star_hit   (hit[g]),
      .bright     (bright[g])
    );
  end

  logic [23:0] pixel_rgb_q, pixel_rgb_d;
  logic        star_on_q, star_on_d;
  logic [2:0]  pixel_layer_q, pixel_layer_d;

  // Ascending scan: a later (nearer) hit overwrites an earlier one.
  always_comb begin
    star_on_d     = 1'b0;
    pixel_layer_d = '0;
    pixel_rgb_d   = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_en[i] && hit[i]) begin
        star_on_d     = 1'b1;
        pixel_layer_d = 3'(i);
        pixel_rgb_d   = {3{bright[i]}};
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_rgb_q   <= '0;
      star_on_q     <= 1'b0;
      pixel_layer_q <= '0;
    end else begin
      pixel_rgb_q   <= pixel_rgb_d;
      star_on_q     <= star_on_d;
      pixel_layer_q <= pixel_layer_d;
    end
  end

  assign pixel_rgb   = pixel_rgb_q;
  assign star_on     = star_on_q;
  assign pixel_layer = pixel_layer_q;

endmodule

// File: tb/tb_starfield_stack.sv
// tb_starfield_stack: self-checking bench for starfield_stack. Two instances
// share all inputs: "dut" uses the sparse mask 21'h1FFFF0, "dut_a" uses
// 21'h1FFFFF so every layer's star test is always true. A reference model of
// the layer state predicts both; predictions are queued at drive time and
// compared after each edge.
module tb_starfield_stack;

  localparam int NL = 2;
  localparam int L  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs = 1'b0;
  logic          pause = 1'b0;
  logic [NL-1:0] en = 2'b11;

  logic [23:0] rgb, rgb_a;
  logic        star, star_a;
  logic [2:0]  lay, lay_a;

  always #5 clk = ~clk;

  starfield_stack #(.WIDTH(8), .HEIGHT(4), .LAYERS(NL), .SPEED_STEP(1),
                    .MASK(21'h1FFFF0), .BASE_SEED(21'h9A9A9)) dut (
    .pixel_clock(clk), .reset_n(rst_n), .frame_start(fs), .pause(pause),
    .layer_en(en), .pixel_rgb(rgb), .star_on(star), .pixel_layer(lay));

  starfield_stack #(.WIDTH(8), .HEIGHT(4), .LAYERS(NL), .SPEED_STEP(1),
                    .MASK(21'h1FFFFF), .BASE_SEED(21'h9A9A9)) dut_a (
    .pixel_clock(clk), .reset_n(rst_n), .frame_start(fs), .pause(pause),
    .layer_en(en), .pixel_rgb(rgb_a), .star_on(star_a), .pixel_layer(lay_a));

  typedef struct packed {
    logic        star;
    logic [23:0] rgb;
    logic [2:0]  lay;
    logic        star_a;
    logic [23:0] rgb_a;
    logic [2:0]  lay_a;
  } exp_t;

  typedef struct {
    logic [1:0] en;
    logic       star;
    logic [2:0] lay;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t ref_stream[40];
  int   cap_n = 0;
  bit   cap   = 1'b0;

  logic [20:0] seeds [NL] = '{21'h9A9A9, 21'h90C0C};
  logic [20:0] mlfsr [NL];
  int          mcnt  [NL];
  logic [7:0]  mfc   [NL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_now();
    exp_t d;
    d = {star, rgb, lay, star_a, rgb_a, lay_a};
    return d;
  endfunction

  function automatic logic [7:0] mbright(input int i);
`ifdef STARFIELD_TWINKLE_EN
    return mlfsr[i][7:0] ^ {mfc[i][2:0], 5'b0};
`else
    return mlfsr[i][7:0];
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t       e;
    logic [7:0] b;
    e = '0;
    for (int i = 0; i < NL; i++) begin
      b = mbright(i);
      if (en[i] && ((mlfsr[i] | 21'h1FFFF0) == 21'h1FFFFF)) begin
        e.star = 1'b1; e.rgb = {b, b, b}; e.lay = 3'(i);
      end
      if (en[i]) begin
        e.star_a = 1'b1; e.rgb_a = {b, b, b}; e.lay_a = 3'(i);
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      mcnt[i] = 0; mlfsr[i] = seeds[i]; mfc[i] = 8'd0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < NL; i++) begin
      if (fs) begin
        mcnt[i] = 0; mlfsr[i] = seeds[i]; mfc[i] = 8'd0;
      end else if (!pause) begin
        if (mcnt[i] == L - 1) mfc[i] = mfc[i] + 8'd1;
        if (mcnt[i] == L - 1 - (i + 1)) mlfsr[i] = seeds[i];
        else mlfsr[i] = mlfsr[i][0] ? ((mlfsr[i] >> 1) ^ 21'h140000) : (mlfsr[i] >> 1);
        mcnt[i] = (mcnt[i] == L - 1) ? 0 : mcnt[i] + 1;
      end
    end
  endtask

  // One pixel: predict from current model state, clock, then compare.
  task automatic step();
    exp_t e;
    e = model_out();
    sb.push_back(e);
    if (cap && cap_n < 40) begin
      ref_stream[cap_n] = e;
      cap_n++;
    end
    @(posedge clk);
    model_tick();
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("stream", 64'(dut_now()), 64'(e));
    end
  endtask

  initial begin
    vec_t tbl[4];
    exp_t held;
    int   guard;
    tbl[0] = '{en: 2'b11, star: 1'b1, lay: 3'd1};
    tbl[1] = '{en: 2'b01, star: 1'b1, lay: 3'd0};
    tbl[2] = '{en: 2'b00, star: 1'b0, lay: 3'd0};
    tbl[3] = '{en: 2'b10, star: 1'b1, lay: 3'd1};

    model_reset();
    #2;
    chk("reset_state", 64'(dut_now()), 64'h0);
    #10 rst_n = 1'b1;

    // Priority table on the always-star instance.
    for (int v = 0; v < 4; v++) begin
      en = tbl[v].en;
      for (int c = 0; c < 3; c++) begin
        step();
        chk("prio_star", 64'(star_a), 64'(tbl[v].star));
        chk("prio_layer", 64'(lay_a), 64'(tbl[v].lay));
        if (!tbl[v].star) chk("prio_rgb_off", 64'(rgb_a), 64'h0);
      end
    end

    // Asynchronous reset mid-run: outputs clear before any edge.
    en = 2'b11;
    step();
    chk("pre_reset_star", 64'(star_a), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'(dut_now()), 64'h0);
    model_reset();
    #3 rst_n = 1'b1;

    // First post-reset pixel shows layer 1 at its seed (low byte 0x0C).
    cap = 1'b1;
    step();
    chk("seed_layer1", 64'(rgb_a), 64'h0C0C0C);
    en = 2'b01;
    step();
    en = 2'b11;
    // Layer 0 alone was shown for one pixel, so keep the capture aligned
    // only from a clean restart below.
    cap = 1'b0;
    cap_n = 0;
    rst_n = 1'b0;
    model_reset();
    #4 rst_n = 1'b1;
    cap = 1'b1;

    // Free run four frames against the model.
    for (int k = 0; k < 4 * L; k++) step();
    cap = 1'b0;

    // Pause: state holds, outputs repeat.
    pause = 1'b1;
    step();
    held = model_out();
    for (int k = 0; k < 9; k++) begin
      step();
      chk("pause_hold", 64'(dut_now()), 64'(held));
    end
    pause = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // frame_start at cnt=17 while paused: stream restarts like post-reset.
    guard = 0;
    while (mcnt[0] != 17 && guard < 2 * L) begin
      step();
      guard++;
    end
    chk("reach_cnt17", 64'(mcnt[0]), 64'd17);
    pause = 1'b1;
    step();
    fs = 1'b1;
    step();
    fs = 1'b0;
    pause = 1'b0;
    for (int j = 0; j < 40; j++) begin
      step();
      chk("fs_vs_reset", 64'(dut_now()), 64'(ref_stream[j]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
